// File: rtl/fb_port_arbiter_if.sv
// Bundle of the clear-control, requester and BRAM-side signals of the frame-buffer arbiter.
// The arbiter uses the slave view; requesters and the BRAM model use the master view.
interface fb_port_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 14
);
    logic             clr_start;
    logic [WIDTH-1:0] clr_value;
    logic             clr_busy;

    logic             a_req;
    logic [AW-1:0]    a_addr;
    logic             a_gnt;
    logic             a_rvalid;
    logic [WIDTH-1:0] a_rdata;

    logic             b_req;
    logic             b_we;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] b_wdata;
    logic             b_gnt;
    logic             b_rvalid;
    logic [WIDTH-1:0] b_rdata;

    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_din;
    logic             mem_we;
    logic [WIDTH-1:0] mem_dout;

    modport slave (
        input  clr_start, clr_value, a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_dout,
        output clr_busy, a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
               mem_addr, mem_din, mem_we
    );

    modport master (
        output clr_start, clr_value, a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_dout,
        input  clr_busy, a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
               mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer BRAM owner: A (scan-out) / B (draw) arbitration with
// B anti-starvation, plus a full-buffer clear sequencer.
module fb_port_arbiter #(
    parameter int WIDTH      = 8,
    parameter int LEN        = 12800,
    parameter int AW         = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fb_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] LEN_A  = AW'(LEN);
    localparam logic [AW-1:0] LAST_A = AW'(LEN - 1);
    localparam logic [SW-1:0] SMAX   = SW'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0] clr_val_q, clr_val_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             a_rv_q, a_rv_d;
    logic             b_rv_q, b_rv_d;
    logic             oor_q, oor_d;

    logic             a_gnt_s, b_gnt_s, b_win_s, mem_we_s;
    logic [AW-1:0]    mem_addr_s;
    logic [WIDTH-1:0] mem_din_s;

    // Next-state, arbitration and BRAM drive
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_val_d  = clr_val_q;
        starve_d   = starve_q;
        a_rv_d     = 1'b0;
        b_rv_d     = 1'b0;
        oor_d      = 1'b0;
        a_gnt_s    = 1'b0;
        b_gnt_s    = 1'b0;
        b_win_s    = 1'b0;
        mem_we_s   = 1'b0;
        mem_addr_s = '0;
        mem_din_s  = bus.b_wdata;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    // A clear request pre-empts any pending port request this cycle.
                    clr_val_d = bus.clr_value;
                    clr_cnt_d = '0;
                    starve_d  = '0;
                    state_d   = ST_CLEAR;
                end else begin
                    b_win_s = bus.b_req && (!bus.a_req || (starve_q == SMAX));
                    if (b_win_s) begin
                        b_gnt_s    = 1'b1;
                        mem_addr_s = bus.b_addr;
                        mem_we_s   = bus.b_we && (bus.b_addr < LEN_A);
                        b_rv_d     = !bus.b_we;
                        oor_d      = !(bus.b_addr < LEN_A);
                        starve_d   = '0;
                    end else if (bus.a_req) begin
                        a_gnt_s    = 1'b1;
                        mem_addr_s = bus.a_addr;
                        a_rv_d     = 1'b1;
                        oor_d      = !(bus.a_addr < LEN_A);
                        starve_d   = bus.b_req ? (starve_q + SW'(1)) : '0;
                    end else begin
                        starve_d   = '0;
                    end
                end
            end
            ST_CLEAR: begin
                mem_we_s   = 1'b1;
                mem_addr_s = clr_cnt_q;
                mem_din_s  = clr_val_q;
                starve_d   = '0;
                if (clr_cnt_q == LAST_A) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and read-return flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            clr_val_q <= '0;
            starve_q  <= '0;
            a_rv_q    <= 1'b0;
            b_rv_q    <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            clr_val_q <= clr_val_d;
            starve_q  <= starve_d;
            a_rv_q    <= a_rv_d;
            b_rv_q    <= b_rv_d;
            oor_q     <= oor_d;
        end
    end

    // BRAM side is held quiet while reset is asserted so nothing is written.
    assign bus.a_gnt    = rst_n && a_gnt_s;
    assign bus.b_gnt    = rst_n && b_gnt_s;
    assign bus.mem_we   = rst_n && mem_we_s;
    assign bus.mem_addr = rst_n ? mem_addr_s : '0;
    assign bus.mem_din  = mem_din_s;
    assign bus.clr_busy = (state_q == ST_CLEAR);
    assign bus.a_rvalid = a_rv_q;
    assign bus.b_rvalid = b_rv_q;
    assign bus.a_rdata  = (a_rv_q && !oor_q) ? bus.mem_dout : '0;
    assign bus.b_rdata  = (b_rv_q && !oor_q) ? bus.mem_dout : '0;
endmodule
